// File: rtl/st_pattern_source.sv
// Avalon-ST source emitting one packet of a counting pattern per start command.
// Each 32-bit lane of beat n carries seed + n*LANES + lane, wrapping modulo 2^32.
module st_pattern_source #(
    parameter int DATA_WIDTH = 256,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      beat_count,
    input  logic [31:0]           seed,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  sop,
    output logic                  eop,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      beats_sent
);
    localparam int          NL    = DATA_WIDTH / 32;
    localparam logic [31:0] LANES = 32'(NL);
    localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] TWO = (LEN_W+1)'(2);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [31:0]           base_q, base_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_d, sop_d, eop_d, busy_d, done_d;
    logic [LEN_W-1:0]      cnt_d;
    logic                  fire, last;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] b);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < NL; k++) p[32*k +: 32] = b + 32'(k);
        return p;
    endfunction

    assign fire = valid && ready;
    // beats_sent counts completed transfers, so the beat on the bus is index beats_sent
    assign last = ({1'b0, beats_sent} + ONE) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            base_q     <= '0;
            st_data    <= '0;
            valid      <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beats_sent <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            base_q     <= base_d;
            st_data    <= data_d;
            valid      <= valid_d;
            sop        <= sop_d;
            eop        <= eop_d;
            busy       <= busy_d;
            done       <= done_d;
            beats_sent <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (beat_count != '0) ? SEND : FINISH;
            SEND:    if (fire && last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        base_d  = base_q;
        data_d  = st_data;
        valid_d = valid;
        sop_d   = sop;
        eop_d   = eop;
        busy_d  = busy;
        done_d  = 1'b0;
        cnt_d   = beats_sent;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    cnt_d = '0;
                    if (beat_count != '0) begin
                        len_d   = beat_count;
                        base_d  = seed;
                        data_d  = pattern(seed);
                        valid_d = 1'b1;
                        sop_d   = 1'b1;
                        eop_d   = (beat_count == LEN_W'(1));
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (fire) begin
                    if (last) begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = len_q;
                    end else begin
                        base_d = base_q + LANES;
                        data_d = pattern(base_q + LANES);
                        sop_d  = 1'b0;
                        eop_d  = ({1'b0, beats_sent} + TWO) == {1'b0, len_q};
                        cnt_d  = beats_sent + LEN_W'(1);
                    end
                end
            end
            FINISH: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_st_pattern_source.sv
// Scoreboard bench for st_pattern_source: driver queues expected beats per command,
// a negedge monitor pops and compares every accepted beat.
module tb_st_pattern_source;
    localparam int DW = 256;
    localparam int LW = 16;
    localparam int NL = DW / 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 0, rst = 1, start = 0, ready = 1;
    logic [LW-1:0] beat_count = '0;
    logic [31:0]   seed = '0;
    logic [DW-1:0] st_data;
    logic          valid, sop, eop, busy, done;
    logic [LW-1:0] beats_sent;

    beat_t sbq[$];
    int    rp[$];
    int    n_chk = 0, n_fail = 0, n_xfer = 0, n_done = 0;

    st_pattern_source #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .beat_count(beat_count), .seed(seed),
        .st_data(st_data), .valid(valid), .ready(ready), .sop(sop), .eop(eop),
        .busy(busy), .done(done), .beats_sent(beats_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: a beat presented with valid&&ready at negedge transfers on the next posedge.
    logic          stall_q = 0;
    logic [DW-1:0] pd;
    logic          ps, pe;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", DW'(valid), DW'(1));
                chk("stall_data", st_data, pd);
                chk("stall_sopeop", DW'({sop, eop}), DW'({ps, pe}));
            end
            if (valid && ready) begin
                n_xfer++;
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    beat_t e;
                    e = sbq.pop_front();
                    chk("beat_data", st_data, e.data);
                    chk("beat_sopeop", DW'({sop, eop}), DW'({e.sop, e.eop}));
                end
            end
            stall_q = valid && !ready;
            pd = st_data; ps = sop; pe = eop;
            if (done) n_done++;
        end
    end

    function automatic logic [DW-1:0] pat(input logic [31:0] s, input int n);
        logic [DW-1:0] p;
        for (int k = 0; k < NL; k++) p[32*k +: 32] = s + 32'(n * NL + k);
        return p;
    endfunction

    task automatic push_pkt(input logic [31:0] s, input int len);
        for (int n = 0; n < len; n++) begin
            beat_t b;
            b.data = pat(s, n);
            b.sop  = (n == 0);
            b.eop  = (n == len - 1);
            sbq.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ready = (rp.size() != 0) ? rp.pop_front()[0] : 1'b1;
    endtask

    task automatic cmd(input logic [31:0] s, input int len);
        start = 1; seed = s; beat_count = LW'(len);
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int i;
        i = 0;
        while (!done && i < bound) begin tick(); i++; end
        chk(name, DW'(done), DW'(1));
    endtask

    initial begin
        int d0, x0;
        tick(); tick();
        chk("rst_valid", DW'(valid), 0);
        chk("rst_flags", DW'({sop, eop, busy, done}), 0);
        chk("rst_data", st_data, 0);
        chk("rst_beats_sent", DW'(beats_sent), 0);
        rst = 0;
        tick();

        // Basic packet, beat 0 and 2 given as hand-written lane values.
        begin
            beat_t b;
            b.data = {32'h10000007, 32'h10000006, 32'h10000005, 32'h10000004,
                      32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000};
            b.sop = 1; b.eop = 0; sbq.push_back(b);
            b.data = pat(32'h10000000, 1); b.sop = 0; sbq.push_back(b);
            b.data = {32'h10000017, 32'h10000016, 32'h10000015, 32'h10000014,
                      32'h10000013, 32'h10000012, 32'h10000011, 32'h10000010};
            b.eop = 1; sbq.push_back(b);
        end
        cmd(32'h10000000, 3);
        chk("basic_first_valid", DW'({valid, sop, busy}), DW'(3'b111));
        tick(); tick();
        chk("basic_third_eop", DW'({valid, eop}), DW'(2'b11));
        tick();
        chk("basic_done", DW'({done, valid, busy}), DW'(3'b100));
        chk("basic_beats_sent", DW'(beats_sent), DW'(3));
        tick();
        chk("basic_done_once", DW'(done), 0);

        // Single beat: busy for exactly one cycle.
        tick();
        push_pkt(32'd5, 1);
        cmd(32'd5, 1);
        chk("single_first", DW'({valid, sop, eop, busy}), DW'(4'b1111));
        tick();
        chk("single_done", DW'({done, busy, valid}), DW'(3'b100));
        chk("single_beats_sent", DW'(beats_sent), DW'(1));
        tick();
        chk("single_done_once", DW'(done), 0);

        // Backpressure.
        tick();
        x0 = n_xfer;
        push_pkt(32'hABCD0000, 4);
        rp = '{1, 0, 0, 1, 1, 0, 1};
        cmd(32'hABCD0000, 4);
        wait_done("bp_done", 20);
        chk("bp_xfers", DW'(n_xfer - x0), DW'(4));
        chk("bp_beats_sent", DW'(beats_sent), DW'(4));
        tick(); tick();

        // Zero length: no valid, done on the following cycle.
        x0 = n_xfer;
        cmd(32'h0, 0);
        chk("zero_done", DW'({done, valid, busy}), DW'(3'b100));
        tick();
        chk("zero_done_once", DW'({done, valid}), 0);
        chk("zero_no_xfer", DW'(n_xfer - x0), 0);
        tick();

        // Wrap-around across 2^32.
        begin
            beat_t b;
            b.data = {32'h3, 32'h2, 32'h1, 32'h0,
                      32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
            b.sop = 1; b.eop = 1; sbq.push_back(b);
        end
        cmd(32'hFFFFFFFC, 1);
        wait_done("wrap_done", 10);
        tick(); tick();

        // Start pulsed mid-packet is ignored.
        x0 = n_xfer; d0 = n_done;
        push_pkt(32'h00C0FFEE, 5);
        cmd(32'h00C0FFEE, 5);
        tick();
        start = 1; seed = 32'h12345678; beat_count = LW'(3);
        tick();
        start = 0;
        wait_done("ign_done", 20);
        for (int i = 0; i < 6; i++) tick();
        chk("ign_xfers", DW'(n_xfer - x0), DW'(5));
        chk("ign_single_done", DW'(n_done - d0), DW'(1));

        // Reset mid-packet, then a clean packet.
        push_pkt(32'h55550000, 6);
        cmd(32'h55550000, 6);
        tick();
        rst = 1;
        tick();
        chk("rstmid_outputs", DW'({valid, busy, done, sop, eop}), 0);
        chk("rstmid_beats_sent", DW'(beats_sent), 0);
        rst = 0;
        sbq.delete();
        d0 = n_done;
        tick(); tick();
        chk("rstmid_no_done", DW'(n_done - d0), 0);
        push_pkt(32'h77770000, 2);
        cmd(32'h77770000, 2);
        chk("rstmid_clean_sop", DW'({valid, sop}), DW'(2'b11));
        wait_done("rstmid_done", 10);
        chk("rstmid_beats_sent2", DW'(beats_sent), DW'(2));
        tick(); tick();

        chk("scoreboard_empty", DW'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
